argo_pipe_nstage: RTL and testbench



---
 rtl/argo_pipe_nstage.sv | 135 +++++++++++++
 tb/tb_argo_pipe_nstage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/argo_pipe_nstage.sv
// Elastic, bubble-collapsing N-stage valid/ready pipeline with optional per-stage add.
// Optional statistics counters are built when ARGO_PIPE_STATS_EN is defined.

module argo_pipe_stage #(
  parameter int               WIDTH  = 32,
  parameter int               MODE   = 0,
  parameter logic [WIDTH-1:0] STEP_W = '0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ld_i,
  input  logic             vld_d_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);
  logic             vld_q;
  logic [WIDTH-1:0] dat_q;

  // Data only moves with a valid beat so an emptied stage keeps its last value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d_i;
      if (ld_i) dat_q <= (MODE == 1) ? dat_i + STEP_W : dat_i;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;
endmodule

module argo_pipe_nstage #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int MODE   = 0,
  parameter int STEP   = 1
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        ivalid,
  output logic                        oready,
  input  logic [WIDTH-1:0]            datain,
  output logic                        ovalid,
  input  logic                        iready,
  output logic [WIDTH-1:0]            dataout,
  input  logic                        flush,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 beats_out
);
  localparam int               OCC_W  = $clog2(STAGES+1);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [STAGES-1:0]            vld_q, vld_d, vld_in, en, ld;
  logic [STAGES-1:0][WIDTH-1:0] dat_q, dat_in;
  logic [OCC_W-1:0]             occ_q, occ_d;
  logic                         accept;

  // A stage may advance if the one ahead advances or it holds no beat itself.
  always_comb begin
    en = '0;
    en[STAGES-1] = iready | ~vld_q[STAGES-1];
    for (int k = STAGES-2; k >= 0; k--) en[k] = en[k+1] | ~vld_q[k];
  end

  assign oready = en[0] & ~flush;
  assign accept = ivalid & oready;

  always_comb begin
    vld_in    = '0;
    dat_in    = '0;
    vld_in[0] = accept;
    dat_in[0] = datain;
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k] = vld_q[k-1];
      dat_in[k] = dat_q[k-1];
    end
  end

  always_comb begin
    vld_d = '0;
    ld    = '0;
    occ_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = flush ? 1'b0 : (en[k] ? vld_in[k] : vld_q[k]);
      ld[k]    = en[k] & vld_in[k];
      occ_d    = occ_d + OCC_W'(vld_d[k]);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    argo_pipe_stage #(.WIDTH(WIDTH), .MODE(MODE), .STEP_W(STEP_W)) u_stage (
      .clock   (clock),
      .resetn  (resetn),
      .ld_i    (ld[k]),
      .vld_d_i (vld_d[k]),
      .dat_i   (dat_in[k]),
      .vld_o   (vld_q[k]),
      .dat_o   (dat_q[k])
    );
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) occ_q <= '0;
    else         occ_q <= occ_d;
  end

  assign ovalid    = vld_q[STAGES-1];
  assign dataout   = dat_q[STAGES-1];
  assign occupancy = occ_q;

`ifdef ARGO_PIPE_STATS_EN
  logic [31:0] stall_q, beats_q;

  // Flush leaves these alone; only reset clears them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(ovalid & ~iready);
      beats_q <= beats_q + 32'(ovalid & iready);
    end
  end

  assign stall_cycles = stall_q;
  assign beats_out    = beats_q;
`else
  assign stall_cycles = '0;
  assign beats_out    = '0;
`endif
endmodule

// File: tb/tb_argo_pipe_nstage.sv
// Scoreboard bench for argo_pipe_nstage: a 3-stage pass-through and a 4-stage +1/stage
// instance share stimulus; stats expectations follow ARGO_PIPE_STATS_EN.

module tb_argo_pipe_nstage;
  logic        clock = 1'b0;
  logic        resetn, ivalid, iready, flush;
  logic [31:0] datain;

  logic        oready0, ovalid0, oready1, ovalid1;
  logic [31:0] dataout0, dataout1, stall0, beats0, stall1, beats1;
  logic [1:0]  occ0;
  logic [2:0]  occ1;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit          m_rdy0, m_rdy1;

`ifdef ARGO_PIPE_STATS_EN
  localparam logic [31:0] EXP_STALL = 32'd4;
  localparam logic [31:0] EXP_BEATS = 32'd5;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_BEATS = 32'd0;
`endif

  always #5 clock = ~clock;

  argo_pipe_nstage #(.WIDTH(32), .STAGES(3), .MODE(0), .STEP(1)) u0 (
    .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready0), .datain(datain),
    .ovalid(ovalid0), .iready(iready), .dataout(dataout0), .flush(flush),
    .occupancy(occ0), .stall_cycles(stall0), .beats_out(beats0));

  argo_pipe_nstage #(.WIDTH(32), .STAGES(4), .MODE(1), .STEP(1)) u1 (
    .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready1), .datain(datain),
    .ovalid(ovalid1), .iready(iready), .dataout(dataout1), .flush(flush),
    .occupancy(occ1), .stall_cycles(stall1), .beats_out(beats1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Per-cycle model: occupancy equals beats in flight, ready follows from occupancy.
  always @(negedge clock) begin
    if (!resetn) begin
      q0.delete();
      q1.delete();
    end else begin
      m_rdy0 = !flush && (q0.size() < 3 || iready);
      m_rdy1 = !flush && (q1.size() < 4 || iready);
      chk("rdy0", 32'(oready0), 32'(m_rdy0));
      chk("rdy1", 32'(oready1), 32'(m_rdy1));
      chk("occ0", 32'(occ0), 32'(q0.size()));
      chk("occ1", 32'(occ1), 32'(q1.size()));
      if (ovalid0 && iready) begin
        if (q0.size() == 0) chk("spur0", 32'(ovalid0), 32'd0);
        else                chk("dat0", dataout0, q0.pop_front());
      end
      if (ovalid1 && iready) begin
        if (q1.size() == 0) chk("spur1", 32'(ovalid1), 32'd0);
        else                chk("dat1", dataout1, q1.pop_front());
      end
      if (ivalid && m_rdy0) q0.push_back(datain);
      if (ivalid && m_rdy1) q1.push_back(datain + 32'd4);
      if (flush) begin
        q0.delete();
        q1.delete();
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stream [8];
    int pk;
    stream = '{32'h19700328, 32'h19700101, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    resetn = 1'b0; ivalid = 1'b0; iready = 1'b0; flush = 1'b0; datain = '0;
    #12;
    chk("rst_ov", 32'(ovalid0), 32'd0);
    chk("rst_do", dataout0, 32'd0);
    chk("rst_occ", 32'(occ0), 32'd0);
    chk("rst_rdy", 32'(oready0), 32'd1);
    chk("rst_stall", stall0, 32'd0);
    chk("rst_beats", beats0, 32'd0);
    @(posedge clock); #1 resetn = 1'b1;

    // streaming, latency and order
    iready = 1'b1;
    pk = 0;
    for (int i = 0; i < 8; i++) begin
      ivalid = 1'b1; datain = stream[i];
      tick();
      if (int'(occ0) > pk) pk = int'(occ0);
      if (i == 1) chk("lat_early", 32'(ovalid0), 32'd0);
      if (i >= 2) begin
        chk("lat_ov", 32'(ovalid0), 32'd1);
        chk("lat_do", dataout0, stream[i-2]);
      end
    end
    ivalid = 1'b0;
    tick(); chk("tail_do6", dataout0, stream[6]);
    tick(); chk("tail_do7", dataout0, stream[7]);
    tick(); chk("tail_ov", 32'(ovalid0), 32'd0);
    chk("tail_hold", dataout0, stream[7]);
    chk("occ_peak", 32'(pk), 32'd3);
    tick(2);

    // fill against a stalled sink, then one-cycle swap
    iready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ivalid = 1'b1; datain = 32'hA0 + 32'(i);
      chk("fill_rdy", 32'(oready0), 32'd1);
      tick();
    end
    datain = 32'hA3;
    chk("full_rdy", 32'(oready0), 32'd0);
    chk("full_occ", 32'(occ0), 32'd3);
    chk("full_do", dataout0, 32'hA0);
    iready = 1'b1; #1;
    chk("full_rdy_thru", 32'(oready0), 32'd1);
    tick(); iready = 1'b0;
    chk("swap_occ", 32'(occ0), 32'd3);
    chk("swap_do", dataout0, 32'hA1);
    ivalid = 1'b0; iready = 1'b1;
    tick(6);

    // bubble collapse behind a stalled output
    iready = 1'b0;
    ivalid = 1'b1; datain = 32'hB0; tick();
    ivalid = 1'b0; tick(2);
    ivalid = 1'b1; datain = 32'hB1;
    chk("bub_rdy", 32'(oready0), 32'd1);
    tick();
    chk("bub_occ2", 32'(occ0), 32'd2);
    datain = 32'hB2;
    chk("bub_rdy2", 32'(oready0), 32'd1);
    tick();
    chk("bub_occ3", 32'(occ0), 32'd3);
    chk("bub_full", 32'(oready0), 32'd0);
    ivalid = 1'b0; iready = 1'b1;
    tick(6);

    // 4-stage +1 wraps modulo 2^32
    ivalid = 1'b1; datain = 32'hFFFF_FFFE; tick();
    ivalid = 1'b0; tick(3);
    chk("wrap_ov", 32'(ovalid1), 32'd1);
    chk("wrap_do", dataout1, 32'h0000_0002);
    tick(3);

    // flush with a full pipe and a pending input beat
    iready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ivalid = 1'b1; datain = 32'hC0 + 32'(i); tick();
    end
    datain = 32'hC3;
    chk("pre_fl_occ", 32'(occ0), 32'd3);
    flush = 1'b1; #1;
    chk("fl_rdy", 32'(oready0), 32'd0);
    tick(); flush = 1'b0; ivalid = 1'b0;
    chk("fl_occ", 32'(occ0), 32'd0);
    chk("fl_ov", 32'(ovalid0), 32'd0);
    chk("fl_occ1", 32'(occ1), 32'd0);
    iready = 1'b1; tick(6);
    chk("fl_quiet", 32'(ovalid0), 32'd0);

    // asynchronous reset mid-stream
    iready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ivalid = 1'b1; datain = 32'hD0 + 32'(i); tick();
    end
    ivalid = 1'b0;
    chk("pre_rst_ov", 32'(ovalid0), 32'd1);
    #2 resetn = 1'b0; #1;
    chk("arst_ov", 32'(ovalid0), 32'd0);
    chk("arst_do", dataout0, 32'd0);
    chk("arst_occ", 32'(occ0), 32'd0);
    chk("arst_ov1", 32'(ovalid1), 32'd0);
    @(posedge clock); #1 resetn = 1'b1;
    chk("rel_rdy", 32'(oready0), 32'd1);

    // statistics: 4 stalled cycles with ovalid high, 5 beats out
    @(posedge clock); #1 resetn = 1'b0;
    tick(); resetn = 1'b1;
    iready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ivalid = 1'b1; datain = 32'hE0 + 32'(i); tick();
    end
    ivalid = 1'b0;
    chk("st_ov", 32'(ovalid0), 32'd1);
    chk("st_do", dataout0, 32'hE0);
    tick(4);
    iready = 1'b1;
    ivalid = 1'b1; datain = 32'hE3; tick();
    datain = 32'hE4; tick();
    ivalid = 1'b0; tick(6);
    chk("st_stall", stall0, EXP_STALL);
    chk("st_beats", beats0, EXP_BEATS);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
